mem_access_unit: RTL

//  MEM-stage data-memory access unit; consumes the EX-stage result (ALUout as address, RegB as store data).

---
 rtl/mem_access_unit.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/gnt/rvalid master with byte-lane steering and load extension.
// Result registered (latency 1 for non-mem/misaligned ops); stall held high while a transaction is in REQ or WAIT.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_MemRead,
  input  logic        ex_MemWrite,
  input  logic [1:0]  ex_MemSize,
  input  logic        ex_MemSign,
  input  logic [31:0] ex_ALUout,
  input  logic [31:0] ex_RegB,
  input  logic [4:0]  ex_Rd,
  input  logic        ex_RegWrite,
  input  logic        flush,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_Rd,
  output logic        wb_RegWrite,
  output logic        wb_misalign,
  output logic        wb_buserr
);

  localparam logic [1:0]  S_IDLE  = 2'b00;
  localparam logic [1:0]  S_REQ   = 2'b01;
  localparam logic [1:0]  S_WAIT  = 2'b10;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] to_cnt;
  logic [31:0] cap_addr;
  logic [1:0]  cap_size;
  logic        cap_sign;
  logic [4:0]  cap_rd;
  logic        cap_regwrite;
  logic        kill;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic        is_mem;
  logic        misalign;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic        to_hit;
  logic        kill_now;

  // Lane steering and alignment check on the incoming EX op.
  always_comb begin
    is_mem   = ex_MemRead | ex_MemWrite;
    misalign = 1'b0;
    be_n     = 4'b1111;
    wdata_n  = ex_RegB;
    case (ex_MemSize)
      2'b00: begin
        be_n    = 4'b0001 << ex_ALUout[1:0];
        wdata_n = {4{ex_RegB[7:0]}};
      end
      2'b01: begin
        misalign = ex_ALUout[0];
        be_n     = 4'b0011 << {ex_ALUout[1], 1'b0};
        wdata_n  = {2{ex_RegB[15:0]}};
      end
      default: misalign = |ex_ALUout[1:0];
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (cap_addr[1:0])
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      2'b11:   ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = cap_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (cap_size)
      2'b00:   load_data = {{24{cap_sign & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{cap_sign & ld_half[15]}}, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  assign to_hit     = (to_cnt == TO_LAST);
  assign kill_now   = kill | flush;
  assign stall      = (state == S_REQ) || (state == S_WAIT);
  assign dmem_req   = (state == S_REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = {cap_addr[31:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      to_cnt       <= '0;
      cap_addr     <= '0;
      cap_size     <= '0;
      cap_sign     <= 1'b0;
      cap_rd       <= '0;
      cap_regwrite <= 1'b0;
      kill         <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_Rd        <= '0;
      wb_RegWrite  <= 1'b0;
      wb_misalign  <= 1'b0;
      wb_buserr    <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_misalign <= 1'b0;
      wb_buserr   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_valid && !flush) begin
            if (!is_mem) begin
              wb_valid    <= 1'b1;
              wb_data     <= ex_ALUout;
              wb_Rd       <= ex_Rd;
              wb_RegWrite <= ex_RegWrite;
            end else if (misalign) begin
              wb_valid    <= 1'b1;
              wb_misalign <= 1'b1;
              wb_data     <= ex_ALUout;
              wb_Rd       <= ex_Rd;
              wb_RegWrite <= 1'b0;
            end else begin
              state        <= S_REQ;
              to_cnt       <= '0;
              cap_addr     <= ex_ALUout;
              cap_size     <= ex_MemSize;
              cap_sign     <= ex_MemSign;
              cap_rd       <= ex_Rd;
              cap_regwrite <= ex_RegWrite;
              kill         <= 1'b0;
              we_q         <= ex_MemWrite;
              be_q         <= be_n;
              wdata_q      <= wdata_n;
            end
          end
        end
        S_REQ: begin
          // A grant wins over both flush and timeout: the memory has already taken the request.
          if (dmem_gnt) begin
            if (we_q) begin
              state <= S_IDLE;
              if (!flush) begin
                wb_valid    <= 1'b1;
                wb_data     <= cap_addr;
                wb_Rd       <= cap_rd;
                wb_RegWrite <= 1'b0;
              end
            end else begin
              state  <= S_WAIT;
              kill   <= flush;
              to_cnt <= to_cnt + 16'd1;
            end
          end else if (flush) begin
            state <= S_IDLE;
          end else if (to_hit) begin
            state       <= S_IDLE;
            wb_valid    <= 1'b1;
            wb_buserr   <= 1'b1;
            wb_data     <= cap_addr;
            wb_Rd       <= cap_rd;
            wb_RegWrite <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            state <= S_IDLE;
            if (!kill_now) begin
              wb_valid    <= 1'b1;
              wb_data     <= load_data;
              wb_Rd       <= cap_rd;
              wb_RegWrite <= cap_regwrite;
            end
          end else if (to_hit) begin
            state <= S_IDLE;
            if (!kill_now) begin
              wb_valid    <= 1'b1;
              wb_buserr   <= 1'b1;
              wb_data     <= cap_addr;
              wb_Rd       <= cap_rd;
              wb_RegWrite <= 1'b0;
            end
          end else begin
            to_cnt <= to_cnt + 16'd1;
            if (flush) kill <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
